// File: rtl/ascon_pack.sv
// Shared types, constants and round-constant helper for the ASCON permutation front-end.
package ascon_pack;

  localparam int ROUND_MAX = 12;

  // Five 64-bit words x0..x4; index 2 is the word that receives the round constant.
  typedef logic [0:4][63:0] type_state;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } fsm_state_e;

  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {4'(4'd15 - r), r};
  endfunction

endpackage

// File: rtl/constant_addition.sv
// Round-constant addition p_C: XORs the 8-bit round constant into x2[7:0].
module constant_addition
  import ascon_pack::type_state;
  import ascon_pack::round_const;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  always_comb begin
    state_o         = state_i;
    state_o[2][7:0] = state_i[2][7:0] ^ round_const(round_i);
  end

endmodule

// File: rtl/ascon_round_state.sv
// ASCON state register, round counter and start/done FSM feeding the substitution layer.
// Optional abort input is enabled by defining ASCON_ABORT_EN.
module ascon_round_state
  import ascon_pack::type_state;
  import ascon_pack::fsm_state_e;
  import ascon_pack::ST_IDLE;
  import ascon_pack::ST_RUN;
  import ascon_pack::ST_DONE;
#(
  parameter int ROUND_MAX = ascon_pack::ROUND_MAX,
  parameter int ROUND_B   = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       pa_sel_i,
`ifdef ASCON_ABORT_EN
  input  logic       abort_i,
`endif
  input  type_state  state_i,
  input  type_state  state_fb_i,
  output type_state  state_to_sbox_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o,
  output type_state  state_o
);

  localparam logic [3:0] ROUND_LAST    = 4'(ROUND_MAX - 1);
  localparam logic [3:0] ROUND_START_B = 4'(ROUND_MAX - ROUND_B);

  fsm_state_e fsm_q, fsm_d;
  type_state  state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       abort;

`ifdef ASCON_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Abort outranks the last-round transition so an aborted run never reaches DONE.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: if (start_i) fsm_d = ST_RUN;
      ST_RUN: begin
        if (abort) begin
          fsm_d = ST_IDLE;
        end else if (round_q == ROUND_LAST) begin
          fsm_d = ST_DONE;
        end
      end
      ST_DONE: fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (fsm_q == ST_RUN);
    done_o = (fsm_q == ST_DONE);
  end

  // The counter saturates at the last round; DONE leaves it there until the next start.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    case (fsm_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = state_i;
          round_d = pa_sel_i ? 4'd0 : ROUND_START_B;
        end
      end
      ST_RUN: begin
        if (abort) begin
          round_d = 4'd0;
        end else begin
          state_d = state_fb_i;
          if (round_q != ROUND_LAST) begin
            round_d = round_q + 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= '0;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  constant_addition u_constant_addition (
    .state_i (state_q),
    .round_i (round_q),
    .state_o (state_to_sbox_o)
  );

  assign state_o = state_q;
  assign round_o = round_q;

`ifndef SYNTHESIS
  round_in_range: assert property (@(posedge clock_i) disable iff (reset_i)
    busy_o |-> (round_o <= ROUND_LAST));
`endif

endmodule

// File: tb/tb_ascon_round_state.sv
// Scoreboard bench for ascon_round_state; the diffusion layer is replaced by a simple word-mixing stand-in.
`timescale 1ns/1ps
module tb_ascon_round_state;
  import ascon_pack::*;

  localparam int ROUND_B_TB = 6;

  logic       clock;
  logic       reset;
  logic       start;
  logic       paSel;
  type_state  stateIn;
  type_state  stateFb;
  type_state  stateToSbox;
  logic [3:0] roundOut;
  logic       busy;
  logic       done;
  type_state  stateOut;
`ifdef ASCON_ABORT_EN
  logic       abort;
`endif

  typedef struct {
    type_state result;
    int        startEdge;
    int        rounds;
  } exp_t;

  exp_t expQ[$];
  exp_t popped;
  int   checks = 0;
  int   failures = 0;
  int   cycleCount = 0;
  int   busyRun = 0;
  bit   mixOn = 1'b0;

  ascon_round_state #(.ROUND_MAX(ROUND_MAX), .ROUND_B(ROUND_B_TB)) dut (
    .clock_i         (clock),
    .reset_i         (reset),
    .start_i         (start),
    .pa_sel_i        (paSel),
`ifdef ASCON_ABORT_EN
    .abort_i         (abort),
`endif
    .state_i         (stateIn),
    .state_fb_i      (stateFb),
    .state_to_sbox_o (stateToSbox),
    .round_o         (roundOut),
    .busy_o          (busy),
    .done_o          (done),
    .state_o         (stateOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycleCount++;

  function automatic type_state mixFn(input type_state s);
    type_state  o;
    logic [63:0] t;
    for (int i = 0; i < 5; i++) begin
      t    = s[(i + 1) % 5];
      o[i] = s[i] ^ ((t << 3) | (t >> 61));
    end
    return o;
  endfunction

  // Reference: rounds firstR..stopR-1, each adding ((15-r)*16 + r) to x2 then the optional mixer.
  function automatic type_state refPerm(input type_state s, input int firstR, input int stopR, input bit mix);
    type_state w = s;
    for (int r = firstR; r < stopR; r++) begin
      w[2] = w[2] ^ 64'(((15 - r) * 16) + r);
      if (mix) w = mixFn(w);
    end
    return w;
  endfunction

  function automatic type_state randState();
    type_state s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
    return s;
  endfunction

  assign stateFb = mixOn ? mixFn(stateToSbox) : stateToSbox;

  task automatic checkOutput(input string name, input logic [319:0] actual, input logic [319:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (busy) busyRun++;
      if (done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          popped = expQ.pop_front();
          checkOutput("result", stateOut, popped.result);
          checkOutput("done_latency", cycleCount - popped.startEdge, popped.rounds);
          checkOutput("busy_cycles", busyRun, popped.rounds);
        end
        busyRun = 0;
      end
    end
  end

  // Returns at the negedge just after the start edge (round index = first round).
  task automatic applyStimulus(input type_state s, input bit pa, input bit mix, input bit glitch);
    int guard = 0;
    int firstR;
    firstR = pa ? 0 : ROUND_MAX - ROUND_B_TB;
    @(negedge clock);
    while ((busy || done) && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) checkOutput("idle_timeout", 1, 0);
    mixOn   = mix;
    stateIn = s;
    paSel   = pa;
    start   = 1'b1;
    expQ.push_back('{refPerm(s, firstR, ROUND_MAX, mix), cycleCount + 1, ROUND_MAX - firstR});
    @(negedge clock);
    start   = 1'b0;
    stateIn = randState();
    if (glitch) begin
      repeat (3) @(negedge clock);
      checkOutput("glitch_round", roundOut, firstR + 3);
      start   = 1'b1;
      stateIn = randState();
      @(negedge clock);
      start   = 1'b0;
    end
  endtask

  task automatic waitDone();
    int guard = 0;
    @(negedge clock);
    while (!done && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    if (!done) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((expQ.size() != 0 || busy || done) && guard < 60) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 60) checkOutput("drain_timeout", expQ.size(), 0);
  endtask

  initial begin
    type_state z;
    type_state expSbox;
    type_state rs;
    z       = '0;
    reset   = 1'b1;
    start   = 1'b0;
    paSel   = 1'b0;
    stateIn = '0;
`ifdef ASCON_ABORT_EN
    abort   = 1'b0;
`endif
    repeat (2) @(negedge clock);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_round", roundOut, 0);
    checkOutput("reset_state", stateOut, 0);
    reset = 1'b0;

    // Round constants seen at the sbox input, starting from an all-zero state.
    applyStimulus(z, 1'b1, 1'b0, 1'b0);
    expSbox    = z;
    expSbox[2] = 64'h00000000000000F0;
    checkOutput("sbox_round0", stateToSbox, expSbox);
    checkOutput("round0", roundOut, 0);
    repeat (11) @(negedge clock);
    checkOutput("round11", roundOut, 11);
    expSbox = refPerm(z, 0, 11, 1'b0);
    checkOutput("state_round11", stateOut, expSbox);
    expSbox[2][7:0] = expSbox[2][7:0] ^ 8'h4B;
    checkOutput("sbox_round11", stateToSbox, expSbox);
    waitDone();
    checkOutput("pa_identity_zero", stateOut, 0);

    applyStimulus(z, 1'b0, 1'b0, 1'b0);
    waitDone();
    checkOutput("pb_identity_x2", stateOut[2], 64'h11);

    // Start during RUN is ignored; start in the cycle after done is accepted.
    applyStimulus(randState(), 1'b1, 1'b1, 1'b1);
    waitDone();
    applyStimulus(randState(), 1'b0, 1'b1, 1'b0);
    checkOutput("b2b_busy", busy, 1);

    for (int n = 0; n < 20; n++) begin
      applyStimulus(randState(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    waitDrain();

    applyStimulus(randState(), 1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clock);
    checkOutput("midrun_round", roundOut, 5);
    reset = 1'b1;
    #1;
    expQ.delete();
    busyRun = 0;
    checkOutput("midrun_reset_busy", busy, 0);
    checkOutput("midrun_reset_round", roundOut, 0);
    checkOutput("midrun_reset_state", stateOut, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (15) @(negedge clock);

`ifdef ASCON_ABORT_EN
    rs = randState();
    applyStimulus(rs, 1'b1, 1'b1, 1'b0);
    repeat (11) @(negedge clock);
    checkOutput("abort_round", roundOut, 11);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    expQ.delete();
    busyRun = 0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_round_cleared", roundOut, 0);
    checkOutput("abort_state", stateOut, refPerm(rs, 0, 11, 1'b1));
    repeat (5) @(negedge clock);
`else
    rs = randState();
    applyStimulus(rs, 1'b0, 1'b1, 1'b0);
`endif
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
